// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO divide controller.
// State encoding, HI/LO width and watchdog counter width.
package hilo_pkg;

  localparam int HILO_W = 32;
  localparam int WDOG_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_e;

endpackage

// File: rtl/hilo_div_ctrl.sv
// HI/LO issue/writeback controller for the EX-stage Goldschmidt divider.
// Ports: clk, rst (async, active-high); issue/issue_signed/issue_a/issue_b
//   from EX; flush; mthi/mtlo/mt_data; stall to the pipeline;
//   div_start/div_annul/div_signed/div_a/div_b to the divider;
//   div_result/div_ready from the divider; hi/lo architectural regs;
//   div_err watchdog pulse; div_zero pulse (only with DIV_ZERO_TRAP_EN).
// Optional feature macro: DIV_ZERO_TRAP_EN (zero-divisor trap).
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue,
  input  logic                issue_signed,
  input  logic [HILO_W-1:0]   issue_a,
  input  logic [HILO_W-1:0]   issue_b,
  input  logic                flush,
  input  logic                mthi,
  input  logic                mtlo,
  input  logic [HILO_W-1:0]   mt_data,
  output logic                stall,
  output logic                div_start,
  output logic                div_annul,
  output logic                div_signed,
  output logic [HILO_W-1:0]   div_a,
  output logic [HILO_W-1:0]   div_b,
  input  logic [2*HILO_W-1:0] div_result,
  input  logic                div_ready,
  output logic [HILO_W-1:0]   hi,
  output logic [HILO_W-1:0]   lo,
  output logic                div_err
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic                div_zero
`endif
);

  localparam logic [WDOG_W-1:0] WD_LAST =
    WDOG_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                start_q, start_d;
  logic                annul_q, annul_d;
  logic                err_q, err_d;
  logic                sgn_q, sgn_d;
  logic [HILO_W-1:0]   a_q, a_d;
  logic [HILO_W-1:0]   b_q, b_d;
  logic [HILO_W-1:0]   hi_q, hi_d;
  logic [HILO_W-1:0]   lo_q, lo_d;

  logic b_zero;
  logic accept;
  logic wd_hit;

`ifdef DIV_ZERO_TRAP_EN
  logic zero_q, zero_d;
  assign b_zero = (issue_b == '0);
`else
  assign b_zero = 1'b0;
`endif

  // An issue is accepted only outside BUSY; its own cycle is stalled
  // so the instruction stays in EX until writeback.
  assign accept = issue & ~flush & ~b_zero
                & (state_q != BUSY);
  assign stall  = (state_q == BUSY) | accept;
  assign wd_hit = (wdog_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    start_d = start_q;
    annul_d = 1'b0;
    err_d   = 1'b0;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef DIV_ZERO_TRAP_EN
    zero_d  = issue & ~flush & b_zero
            & (state_q != BUSY);
`endif

    unique case (state_q)
      IDLE, DRAIN: begin
        start_d = 1'b0;
        state_d = IDLE;
        if (accept) begin
          sgn_d   = issue_signed;
          a_d     = issue_a;
          b_d     = issue_b;
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // flush outranks a coincident div_ready
        priority case (1'b1)
          flush: begin
            start_d = 1'b0;
            annul_d = 1'b1;
            state_d = DRAIN;
          end
          div_ready: begin
            hi_d    = div_result[2*HILO_W-1:HILO_W];
            lo_d    = div_result[HILO_W-1:0];
            start_d = 1'b0;
            annul_d = 1'b1;
            state_d = DRAIN;
          end
          wd_hit: begin
            start_d = 1'b0;
            annul_d = 1'b1;
            err_d   = 1'b1;
            state_d = DRAIN;
          end
          default: wdog_d = wdog_q + 1'b1;
        endcase
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // MTHI/MTLO only land when nothing holds EX
    if (~stall) begin
      if (mthi) hi_d = mt_data;
      if (mtlo) lo_d = mt_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      err_q   <= 1'b0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      start_q <= start_d;
      annul_q <= annul_d;
      err_q   <= err_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end
  assign div_zero = zero_q;
`endif

  assign div_start  = start_q;
  assign div_annul  = annul_q;
  assign div_err    = err_q;
  assign div_signed = sgn_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
